// File: rtl/md_joy_pkg.sv
// Shared constants and helpers for the Mega Drive virtual joystick: button
// indices, select-sequence phases and the per-phase pin encoding.
package md_joy_pkg;

    localparam int unsigned PINS_PER_PAD = 6;
    localparam int unsigned BTNS_PER_PAD = 11;

    localparam int unsigned BTN_R     = 0;
    localparam int unsigned BTN_L     = 1;
    localparam int unsigned BTN_D     = 2;
    localparam int unsigned BTN_U     = 3;
    localparam int unsigned BTN_B     = 4;
    localparam int unsigned BTN_C     = 5;
    localparam int unsigned BTN_A     = 6;
    localparam int unsigned BTN_START = 7;
    localparam int unsigned BTN_Y     = 8;
    localparam int unsigned BTN_Z     = 9;
    localparam int unsigned BTN_X     = 10;

    // Even phases are entered with select high, odd phases with select low.
    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_FIRST_LO  = 3'd1,
        PH_SECOND_HI = 3'd2,
        PH_SECOND_LO = 3'd3,
        PH_THIRD_HI  = 3'd4,
        PH_ID_LO     = 3'd5,
        PH_EXT_HI    = 3'd6,
        PH_FINAL_LO  = 3'd7
    } phase_e;

    function automatic phase_e sel_phase(input logic sel);
        return sel ? PH_IDLE : PH_FIRST_LO;
    endfunction

    function automatic logic [PINS_PER_PAD-1:0] encode_pins(
        input phase_e                  ph,
        input logic [BTNS_PER_PAD-1:0] btn
    );
        logic [BTNS_PER_PAD-1:0] n;
        logic [PINS_PER_PAD-1:0] pins;
        n = ~btn;
        case (ph)
            PH_FIRST_LO, PH_SECOND_LO: pins = {n[BTN_START], n[BTN_A], 2'b00, n[BTN_D], n[BTN_U]};
            PH_ID_LO:                  pins = {n[BTN_START], n[BTN_A], 4'b0000};
            PH_EXT_HI:                 pins = {n[BTN_C], n[BTN_B], 1'b1, n[BTN_X], n[BTN_Y], n[BTN_Z]};
            PH_FINAL_LO:               pins = {n[BTN_START], n[BTN_A], 4'b1111};
            default:                   pins = {n[BTN_C], n[BTN_B], n[BTN_R], n[BTN_L], n[BTN_D], n[BTN_U]};
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/md_joy_pad.sv
// One emulated pad: select synchroniser, select-phase FSM with idle timeout,
// and the registered active-low pin mux.
module md_joy_pad
    import md_joy_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 42000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BTNS_PER_PAD-1:0] btn_i,
    input  logic                    six_en_i,
    input  logic                    pin7_i,
    output logic [PINS_PER_PAD-1:0] pins_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sel_dly_q;
    logic                    mode_q;
    phase_e                  phase_q, phase_d;
    logic [CNT_W-1:0]        idle_q, idle_d;
    logic [PINS_PER_PAD-1:0] pins_q;

    logic sel;
    logic sel_edge;
    logic mode_chg;
    logic timed_out;

    assign sel       = sync_q[SYNC_STAGES-1];
    assign sel_edge  = sel != sel_dly_q;
    assign mode_chg  = six_en_i != mode_q;
    assign timed_out = idle_q == IDLE_MAX;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        phase_d = phase_q;
        idle_d  = timed_out ? idle_q : idle_q + 1'b1;

        if (mode_chg) begin
            phase_d = sel_phase(sel);
            idle_d  = '0;
        end else if (sel_edge) begin
            idle_d  = '0;
            phase_d = six_en_i ? phase_e'(phase_q + 3'd1) : sel_phase(sel);
        end else if (!six_en_i || timed_out) begin
            phase_d = sel_phase(sel);
        end
    end

    // mode_q resets to 0; a 6-button pad then sees one mode change right after
    // reset, which forces the same phase reset already gave it (sel is high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            sel_dly_q <= 1'b1;
            mode_q    <= 1'b0;
            phase_q   <= PH_IDLE;
            idle_q    <= '0;
            pins_q    <= '1;
        end else begin
            // NOTE: non-blocking assignments keep each flop sampling pre-edge values.
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pin7_i};
            sel_dly_q <= sel;
            mode_q    <= six_en_i;
            phase_q   <= phase_d;
            idle_q    <= idle_d;
            pins_q    <= encode_pins(phase_d, btn_i);
        end
    end

    assign pins_o = pins_q;

endmodule

// File: rtl/md_multi_virtual_joystick.sv
// Multi-pad Mega Drive joystick emulator: NUM_PADS independent pads driven from
// virtual button vectors, each answering its own console select line.
module md_multi_virtual_joystick
    import md_joy_pkg::*;
#(
    parameter int unsigned NUM_PADS       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 42000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PADS*BTNS_PER_PAD-1:0] vj,
    input  logic [NUM_PADS-1:0]              six_button_en,
    input  logic [NUM_PADS-1:0]              pin_7,
    output logic [NUM_PADS*PINS_PER_PAD-1:0] data_bits
);

    for (genvar n = 0; n < NUM_PADS; n++) begin : g_pad
        md_joy_pad #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_pad (
            .clk     (clk),
            .rst     (reset),
            .btn_i   (vj[n*BTNS_PER_PAD +: BTNS_PER_PAD]),
            .six_en_i(six_button_en[n]),
            .pin7_i  (pin_7[n]),
            .pins_o  (data_bits[n*PINS_PER_PAD +: PINS_PER_PAD])
        );
    end

endmodule
